joypad_debounce: RTL and testbench
==================================

JOYPAD_DEBOUNCE -- requirements
Module: joypad_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000 (5 ms at 100 MHz), is the number of consecutive cycles a synchronized input must differ from the stable state before the stable state updates; legal range is 1 or greater.
REQ-002 Parameter CNT_W, default max($clog2(DEBOUNCE_CYCLES),1), is the per-button counter width; it is derived and is never overridden.
REQ-003 clk_in  input  1  system clock; single clock domain.
REQ-004 rst_n_in  input  1  asynchronous, active-low reset.
REQ-005 pmoda_raw  input  8  raw, asynchronous, active-high button levels: 0 A, 1 B, 2 Select, 3 Start, 4 Right, 5 Left, 6 Up, 7 Down.
REQ-006 btn_out  output  8  debounced active-high button state, same bit map; feeds the joypad matrix stage's pmoda input.
REQ-007 press_pulse  output  8  one-cycle pulse per bit when the matching btn_out bit rises 0->1.
REQ-008 irq_out  output  1  one-cycle joypad interrupt request (see Configuration).

Function
REQ-009 Each bit shall pass through a 2-flop synchronizer (sync1, sync2) before any other logic uses it.
REQ-010 Each bit shall hold an independent CNT_W-bit counter and a stable bit; btn_out equals the stable bits.
REQ-011 On any cycle where sync2 equals stable, that bit's counter shall clear to 0.
REQ-012 On any cycle where sync2 differs from stable and counter < DEBOUNCE_CYCLES-1, the counter shall increment by 1.
REQ-013 On any cycle where sync2 differs from stable and counter == DEBOUNCE_CYCLES-1, stable shall take sync2 and the counter shall clear to 0 on the same edge.
REQ-014 Latency: a pmoda_raw change held constant shall appear on btn_out exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
REQ-015 Glitch rejection: a difference lasting fewer than DEBOUNCE_CYCLES cycles at sync2 shall leave stable unchanged and clear the counter.
REQ-016 The counter shall never exceed DEBOUNCE_CYCLES-1; it shall not wrap.
REQ-017 press_pulse[i] shall be registered and shall assert for exactly the one cycle after the edge where stable[i] goes 0->1; a 1->0 transition shall produce no pulse.
REQ-018 Simultaneous qualifying transitions on several bits shall each pulse independently in the same cycle.
REQ-019 Bits are fully independent; activity on one bit shall not affect any other bit's counter or timing.

Reset
REQ-020 While rst_n_in is low, sync1, sync2, stable, all counters, press_pulse and irq_out shall be 0 immediately, without waiting for a clock edge.
REQ-021 Reset asserted mid-count shall discard the count.
REQ-022 After reset release, a button already held shall register as a new press and pulse after DEBOUNCE_CYCLES+2 edges.
REQ-023 No output shall glitch high in the cycle after reset release.

Configuration
REQ-024 Macro JOYPAD_DEBOUNCE_IRQ_EN defined: irq_out shall be the registered OR of all press_pulse bits, asserting in the same cycle as the pulses.
REQ-025 Macro JOYPAD_DEBOUNCE_IRQ_EN undefined: irq_out shall be constant 0 and the OR/register logic shall be absent; all other behaviour is unchanged.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Reset, then pmoda_raw=8'h01 held -> btn_out=8'h01 exactly 6 edges later, press_pulse=8'h01 for 1 cycle, irq_out=1 for 1 cycle with the macro defined, 0 without.
REQ-027 From btn_out=8'h00, pulse pmoda_raw[4]=1 for 3 cycles then 0 -> btn_out stays 8'h00 and no pulse.
REQ-028 Bit 0 bouncing 1,0,1,0,1 per cycle, then held 1 -> btn_out[0] rises 6 edges after the final rising sample; exactly one pulse.
REQ-029 From btn_out=8'hFF, pmoda_raw=8'h00 held -> btn_out=8'h00 after 6 edges; press_pulse and irq_out stay 0.
REQ-030 pmoda_raw=8'h90 held, rst_n_in pulsed low mid-count -> all outputs 0 asynchronously; after release, btn_out=8'h90 6 edges later with press_pulse=8'h90 for one cycle.

Source files
------------

// File: rtl/joypad_debounce_if.sv
// Button bus between the raw PMOD joypad pins and the debounced joypad outputs.
// The DUT takes the slave modport; whoever drives the raw pins takes the master modport.
interface joypad_debounce_if;
   logic [7:0] pmoda_raw;
   logic [7:0] btn_out;
   logic [7:0] press_pulse;
   logic       irq_out;

   modport master (
      output pmoda_raw,
      input  btn_out,
      input  press_pulse,
      input  irq_out
   );

   modport slave (
      input  pmoda_raw,
      output btn_out,
      output press_pulse,
      output irq_out
   );
endinterface

// File: rtl/joypad_debounce.sv
// Eight-button joypad debouncer: 2-flop synchronizer, per-bit saturating counter, press pulses.
// Define JOYPAD_DEBOUNCE_IRQ_EN to drive irq_out with a registered OR of the press pulses.
module joypad_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   joypad_debounce_if.slave pad
);
   localparam int               NB      = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NB-1:0]    r_sync1;
   logic [NB-1:0]    r_sync2;
   logic [NB-1:0]    r_stable;
   logic [NB-1:0]    r_pulse;
   logic [CNT_W-1:0] r_cnt [NB];

   logic [NB-1:0]    w_stable_next;
   logic [NB-1:0]    w_rise;
   logic [CNT_W-1:0] w_cnt_next [NB];

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= pad.pmoda_raw;
         r_sync2 <= r_sync1;
      end
   end

   // The counter saturates at CNT_MAX: reaching it commits the new level and restarts from 0.
   always_comb begin
      w_stable_next = r_stable;
      for (int i = 0; i < NB; i++) begin
         w_cnt_next[i] = '0;
         if (r_sync2[i] != r_stable[i]) begin
            if (r_cnt[i] == CNT_MAX) begin
               w_stable_next[i] = r_sync2[i];
            end else begin
               w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign w_rise = w_stable_next & ~r_stable;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_stable <= '0;
         r_pulse  <= '0;
         for (int i = 0; i < NB; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_stable <= w_stable_next;
         r_pulse  <= w_rise;
         for (int i = 0; i < NB; i++) begin
            r_cnt[i] <= w_cnt_next[i];
         end
      end
   end

`ifdef JOYPAD_DEBOUNCE_IRQ_EN
   logic r_irq;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |w_rise;
      end
   end

   assign pad.irq_out = r_irq;
`else
   assign pad.irq_out = 1'b0;
`endif

   assign pad.btn_out     = r_stable;
   assign pad.press_pulse = r_pulse;
endmodule

// File: tb/tb_joypad_debounce.sv
// Scoreboard bench for joypad_debounce with DEBOUNCE_CYCLES=4: stimulus queues expected
// output changes (cycle, btn, pulse, irq); a negedge monitor pops one per observed change.
module tb_joypad_debounce;
   localparam int D = 4;
`ifdef JOYPAD_DEBOUNCE_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   typedef struct {
      int         cyc;
      logic [7:0] btn;
      logic [7:0] pulse;
      logic       irq;
   } ev_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;
   ev_t  exp_q[$];
   ev_t  m_ev;
   logic [7:0] m_prev_btn, m_prev_pulse;
   logic       m_prev_irq;

   joypad_debounce_if u_if ();

   joypad_debounce #(
      .DEBOUNCE_CYCLES(D)
   ) u_dut (
      .clk_in  (clk),
      .rst_n_in(rst_n),
      .pad     (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic irq_for(logic [7:0] p);
      return IRQ_EN && (p != 8'h00);
   endfunction

   task automatic expect_ev(int c, logic [7:0] b, logic [7:0] p);
      ev_t e;
      e.cyc   = c;
      e.btn   = b;
      e.pulse = p;
      e.irq   = irq_for(p);
      exp_q.push_back(e);
   endtask

   // A new press: btn and pulse rise together at edge c, pulse drops one edge later.
   task automatic expect_press(int c, logic [7:0] b, logic [7:0] p);
      expect_ev(c, b, p);
      expect_ev(c + 1, b, 8'h00);
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(string name);
      checks++;
      if (u_if.btn_out !== 8'h00 || u_if.press_pulse !== 8'h00 || u_if.irq_out !== 1'b0) begin
         errors++;
         $display("FAIL %s: got btn=%h pulse=%h irq=%b, required all zero", name,
                  u_if.btn_out, u_if.press_pulse, u_if.irq_out);
      end
   endtask

   // Monitor: any change of the outputs outside reset is one event to match.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_prev_btn   = u_if.btn_out;
         m_prev_pulse = u_if.press_pulse;
         m_prev_irq   = u_if.irq_out;
      end else if (u_if.btn_out !== m_prev_btn || u_if.press_pulse !== m_prev_pulse ||
                   u_if.irq_out !== m_prev_irq) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change cyc=%0d: got btn=%h pulse=%h irq=%b, required none",
                     cyc, u_if.btn_out, u_if.press_pulse, u_if.irq_out);
         end else begin
            m_ev = exp_q.pop_front();
            if (m_ev.cyc != cyc || u_if.btn_out !== m_ev.btn ||
                u_if.press_pulse !== m_ev.pulse || u_if.irq_out !== m_ev.irq) begin
               errors++;
               $display("FAIL event: got cyc=%0d btn=%h pulse=%h irq=%b, required cyc=%0d btn=%h pulse=%h irq=%b",
                        cyc, u_if.btn_out, u_if.press_pulse, u_if.irq_out,
                        m_ev.cyc, m_ev.btn, m_ev.pulse, m_ev.irq);
            end
         end
         m_prev_btn   = u_if.btn_out;
         m_prev_pulse = u_if.press_pulse;
         m_prev_irq   = u_if.irq_out;
      end
   end

   initial begin
      int c0;
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      u_if.pmoda_raw = 8'h00;
      #12;
      chk_zero("reset_initial");
      tick(1);
      rst_n = 1'b1;
      tick(3);

      // Single press on A.
      u_if.pmoda_raw = 8'h01;
      c0 = cyc;
      expect_press(c0 + D + 2, 8'h01, 8'h01);
      tick(12);

      // 3-cycle glitch on Right must be rejected.
      u_if.pmoda_raw = 8'h11;
      tick(3);
      u_if.pmoda_raw = 8'h01;
      tick(12);

      // Release A, then bounce A 1,0,1,0,1 and hold.
      u_if.pmoda_raw = 8'h00;
      c0 = cyc;
      expect_ev(c0 + D + 2, 8'h00, 8'h00);
      tick(12);
      c0 = cyc;
      for (int i = 0; i < 5; i++) begin
         u_if.pmoda_raw = (i % 2 == 0) ? 8'h01 : 8'h00;
         tick(1);
      end
      expect_press(c0 + 4 + D + 2, 8'h01, 8'h01);
      tick(12);

      // All buttons: seven simultaneous new presses, then full release without pulses.
      u_if.pmoda_raw = 8'hFF;
      c0 = cyc;
      expect_press(c0 + D + 2, 8'hFF, 8'hFE);
      tick(12);
      u_if.pmoda_raw = 8'h00;
      c0 = cyc;
      expect_ev(c0 + D + 2, 8'h00, 8'h00);
      tick(12);

      // Reset mid-count discards progress; held buttons press again after release.
      u_if.pmoda_raw = 8'h90;
      tick(3);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("reset_mid_count");
      tick(2);
      rst_n = 1'b1;
      c0 = cyc;
      expect_press(c0 + D + 2, 8'h90, 8'h90);
      tick(12);

      // Asynchronous clear of a held state between clock edges.
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("reset_async_held");
      tick(2);
      rst_n = 1'b1;
      c0 = cyc;
      expect_press(c0 + D + 2, 8'h90, 8'h90);
      tick(12);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_events: got %0d unmatched, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
